insn_encoder_writer: RTL and testbench
======================================

Name: insn_encoder_writer

Overview:
- Inverse of the instruction decode path. Accepts decoded instruction fields in OpInfo-style form over a valid/ready handshake.
- Packs the fields into 32-bit RISC-V RV32I instruction words.
- Streams the words into instruction memory at consecutive addresses.
- Serves as the program loader/self-test source that fills IMem before the core runs.

Parameters:
- ADDR_WIDTH, INSN_ADDR_WIDTH, width of the IMem byte address.
- ERR_CNT_WIDTH, 8, width of the saturating illegal-request counter.
- CNT_WIDTH, 16, width of the request-count field.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-low (0 = reset)
- start  input  1  one-cycle pulse; begins a load run
- baseAddr  input  ADDR_WIDTH  first write address, latched on start
- count  input  CNT_WIDTH  number of requests in the run, latched on start
- reqValid  input  1  request fields valid
- reqReady  output  1  request accepted when reqValid && reqReady
- reqOpcode  input  7  opcode
- reqRd / reqRs1 / reqRs2  input  5 each  register numbers
- reqFunct3  input  3  funct3
- reqFunct7  input  7  funct7
- reqConstant  input  32  immediate (ConstantPath), unshifted value
- imemWE  output  1  write valid
- imemReady  input  1  IMem accepts the write this cycle
- imemAddr  output  ADDR_WIDTH  write address
- imemData  output  32  encoded instruction
- busy  output  1  state == RUN
- done  output  1  run complete; held high
- errCount  output  ERR_CNT_WIDTH  illegal requests seen; saturating

Behaviour:
- Reset values: all outputs 0; state IDLE; output register empty.
- States: IDLE, RUN, DONE.
  - IDLE/DONE + start: latch baseAddr and count.
    - count == 0 goes directly to DONE.
    - Otherwise go to RUN and clear errCount.
  - start while in RUN is ignored.
- RUN:
  - remaining counter decrements on every accepted request, legal or illegal.
  - Leave to DONE when remaining == 0 and the output register is empty, or being drained in the same cycle.
- Output register is one entry.
  - reqReady = busy && remaining != 0 && (!imemWE || imemReady). This is a combinational look-through of imemReady.
  - imemWE = output register valid.
  - A write transfers when imemWE && imemReady. The register holds data and address stable until the transfer.
- Latency: request accepted in cycle N gives imemWE high in cycle N+1. Sustained throughput is 1 per cycle while imemReady stays 1.
- Address: wrAddr starts at baseAddr and increments by 4 per completed write. It wraps modulo 2^ADDR_WIDTH.
- Encoding by opcode (imm = reqConstant):
  - OP (R-type): f7 | rs2 | rs1 | f3 | rd | op.
  - LOAD, OP_IMM, JALR, SYSTEM, MISC_MEM (I-type): imm[11:0] | rs1 | f3 | rd | op.
    - OP_IMM with f3 = 001/101: bits[31:25] = f7 and bits[24:20] = imm[4:0].
  - STORE (S-type): imm[11:5] | rs2 | rs1 | f3 | imm[4:0] | op.
  - BRANCH (B-type): imm[12] | imm[10:5] | rs2 | rs1 | f3 | imm[4:1] | imm[11] | op.
  - LUI, AUIPC (U-type): imm[31:12] | rd | op.
  - JAL (J-type): imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | op.
- Illegal request: consumed, never written, does not advance wrAddr; errCount += 1, saturating at all-ones. A request is illegal if any of:
  - opcode is not an OpCode enum value;
  - BRANCH with f3 = 010 or 011;
  - BRANCH or JAL with imm[0] = 1.
- Immediate bits outside the format field are ignored. There is no range check.
- done clears on the cycle after a start that leaves DONE.
- Async reset mid-run returns the block to IDLE immediately. Any in-flight word is dropped and imemWE drops asynchronously.

Decomposition:
- Add to the shared Types package:
  - InsnFormat enum (R, I, S, B, U, J, ILLEGAL);
  - INSN_WIDTH = 32;
  - InsnPath typedef;
  - EncodeReq packed struct (opcode, rd, rs1, rs2, funct3, funct7, constant).
- Reuse the OpCode, BrFunct3 and OP_FUNCT3 enums.
- Sub-module insn_field_packer: purely combinational. Takes EncodeReq and returns InsnPath plus an illegal flag.
- The top level holds the FSM, counters, output register and handshake.

Test Plan:
- add x3,x1,x2 (op 0110011, rd 3, rs1 1, rs2 2, f3 0, f7 0), baseAddr 0x100, count 1 -> one write 0x002081B3 @0x100, then done = 1.
- addi x5,x0,-1 (op 0010011, imm 0xFFFFFFFF), then sw x2,8(x1) (f3 010) -> 0xFFF00293 @base, 0x0020A423 @base+4.
- beq x1,x2,-4 (imm 0xFFFFFFFC) -> 0xFE208EE3; jal x1,+8 -> 0x008000EF.
- count 3, back-to-back requests, imemReady low for 3 cycles after the first write -> reqReady low while stalled, imemData/imemAddr stable, addresses 0x100/0x104/0x108 in order, done after the third transfer.
- Stream of opcode 0x7F, beq with imm 2, then a legal add; count 3 -> errCount = 2, exactly one write at baseAddr, done = 1.
- rst low mid-run with a word pending -> imemWE = 0 immediately, busy/done/errCount = 0. A new start then resumes writing at the new baseAddr.

Source files
------------

// File: rtl/insn_encoder_writer_pkg.sv
// Shared types for the instruction encoder/writer: RV32I opcodes, funct3 enums,
// encoding formats and the decoded-request struct fed to the field packer.
package insn_encoder_writer_pkg;

  localparam int INSN_WIDTH      = 32;
  localparam int INSN_ADDR_WIDTH = 16;

  typedef logic [INSN_WIDTH-1:0] InsnPath;
  typedef logic [31:0]           ConstantPath;

  typedef enum logic [6:0] {
    OPC_LOAD     = 7'b0000011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_OP_IMM   = 7'b0010011,
    OPC_AUIPC    = 7'b0010111,
    OPC_STORE    = 7'b0100011,
    OPC_OP       = 7'b0110011,
    OPC_LUI      = 7'b0110111,
    OPC_BRANCH   = 7'b1100011,
    OPC_JALR     = 7'b1100111,
    OPC_JAL      = 7'b1101111,
    OPC_SYSTEM   = 7'b1110011
  } OpCode;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } BrFunct3;

  typedef enum logic [2:0] {
    F3_ADD_SUB = 3'b000,
    F3_SLL     = 3'b001,
    F3_SLT     = 3'b010,
    F3_SLTU    = 3'b011,
    F3_XOR     = 3'b100,
    F3_SRL_SRA = 3'b101,
    F3_OR      = 3'b110,
    F3_AND     = 3'b111
  } OP_FUNCT3;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILLEGAL
  } InsnFormat;

  // opcode is kept as raw bits so that non-enum values can be flagged illegal
  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    ConstantPath constant;
  } EncodeReq;

  function automatic InsnFormat op_format(input logic [6:0] opcode);
    case (opcode)
      OPC_OP:                                            return FMT_R;
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM,
      OPC_MISC_MEM:                                      return FMT_I;
      OPC_STORE:                                         return FMT_S;
      OPC_BRANCH:                                        return FMT_B;
      OPC_LUI, OPC_AUIPC:                                return FMT_U;
      OPC_JAL:                                           return FMT_J;
      default:                                           return FMT_ILLEGAL;
    endcase
  endfunction

  function automatic logic is_br_funct3(input logic [2:0] f3);
    case (f3)
      BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/insn_field_packer.sv
// Combinational RV32I encoder: packs a decoded request into a 32-bit word and
// flags requests that cannot be encoded.
module insn_field_packer
  import insn_encoder_writer_pkg::*;
(
  input  EncodeReq req,
  output InsnPath  insn,
  output logic     illegal
);

  InsnFormat   fmt;
  ConstantPath imm;
  logic        is_shift_imm;

  always_comb begin
    fmt          = op_format(req.opcode);
    imm          = req.constant;
    is_shift_imm = (req.opcode == OPC_OP_IMM) &&
                   ((req.funct3 == F3_SLL) || (req.funct3 == F3_SRL_SRA));
    insn         = '0;
    illegal      = 1'b0;
    case (fmt)
      FMT_R: insn = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
      FMT_I: begin
        // shift-immediates carry funct7 in the upper bits and a 5-bit shamt
        if (is_shift_imm)
          insn = {req.funct7, imm[4:0], req.rs1, req.funct3, req.rd, req.opcode};
        else
          insn = {imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
      end
      FMT_S: insn = {imm[11:5], req.rs2, req.rs1, req.funct3, imm[4:0], req.opcode};
      FMT_B: insn = {imm[12], imm[10:5], req.rs2, req.rs1, req.funct3,
                     imm[4:1], imm[11], req.opcode};
      FMT_U: insn = {imm[31:12], req.rd, req.opcode};
      FMT_J: insn = {imm[20], imm[10:1], imm[11], imm[19:12], req.rd, req.opcode};
      default: illegal = 1'b1;
    endcase
    if ((fmt == FMT_B) && !is_br_funct3(req.funct3))
      illegal = 1'b1;
    if (((fmt == FMT_B) || (fmt == FMT_J)) && imm[0])
      illegal = 1'b1;
  end

endmodule

// File: rtl/insn_encoder_writer.sv
// Program loader: accepts decoded instruction fields, encodes them and streams
// the words into IMem at consecutive addresses through a one-entry output register.
module insn_encoder_writer
  import insn_encoder_writer_pkg::*;
#(
  parameter int ADDR_WIDTH    = INSN_ADDR_WIDTH,
  parameter int ERR_CNT_WIDTH = 8,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_WIDTH-1:0]    baseAddr,
  input  logic [CNT_WIDTH-1:0]     count,
  input  logic                     reqValid,
  output logic                     reqReady,
  input  logic [6:0]               reqOpcode,
  input  logic [4:0]               reqRd,
  input  logic [4:0]               reqRs1,
  input  logic [4:0]               reqRs2,
  input  logic [2:0]               reqFunct3,
  input  logic [6:0]               reqFunct7,
  input  logic [31:0]              reqConstant,
  output logic                     imemWE,
  input  logic                     imemReady,
  output logic [ADDR_WIDTH-1:0]    imemAddr,
  output logic [31:0]              imemData,
  output logic                     busy,
  output logic                     done,
  output logic [ERR_CNT_WIDTH-1:0] errCount,
  output logic [1:0]               dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]               state;
  logic [CNT_WIDTH-1:0]     remaining;
  logic [ADDR_WIDTH-1:0]    wr_addr;
  logic                     out_valid;
  InsnPath                  out_data;
  logic [ERR_CNT_WIDTH-1:0] err_count;

  EncodeReq req_fields;
  InsnPath  enc_insn;
  logic     enc_illegal;
  logic     accept;
  logic     drain;

  always_comb begin
    req_fields.opcode   = reqOpcode;
    req_fields.rd       = reqRd;
    req_fields.rs1      = reqRs1;
    req_fields.rs2      = reqRs2;
    req_fields.funct3   = reqFunct3;
    req_fields.funct7   = reqFunct7;
    req_fields.constant = reqConstant;
  end

  insn_field_packer u_packer (
    .req     (req_fields),
    .insn    (enc_insn),
    .illegal (enc_illegal)
  );

  // Handshake: a request transfers when reqValid && reqReady; a write transfers
  // when imemWE && imemReady. reqReady looks through imemReady so the single
  // output register can refill in the same cycle it drains.
  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE);
  assign imemWE    = out_valid;
  assign imemAddr  = wr_addr;
  assign imemData  = out_data;
  assign errCount  = err_count;
  assign dbg_state = state;
  assign drain     = out_valid && imemReady;
  assign reqReady  = busy && (remaining != '0) && (!out_valid || imemReady);
  assign accept    = reqValid && reqReady;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      remaining <= '0;
      wr_addr   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      err_count <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            wr_addr   <= baseAddr;
            remaining <= count;
            if (count == '0) begin
              state <= ST_DONE;
            end else begin
              state     <= ST_RUN;
              err_count <= '0;
            end
          end
        end
        ST_RUN: begin
          if (drain)
            wr_addr <= wr_addr + ADDR_WIDTH'(4);
          if (accept) begin
            remaining <= remaining - CNT_WIDTH'(1);
            // illegal requests are consumed without touching the output register
            if (enc_illegal) begin
              if (err_count != '1)
                err_count <= err_count + ERR_CNT_WIDTH'(1);
            end
          end
          if (accept && !enc_illegal) begin
            out_valid <= 1'b1;
            out_data  <= enc_insn;
          end else if (drain) begin
            out_valid <= 1'b0;
          end
          if ((remaining == '0) && (!out_valid || drain))
            state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_insn_encoder_writer.sv
// Randomized self-checking bench for insn_encoder_writer with a behavioural
// encoder model and an expected-write queue.
module tb_insn_encoder_writer;

  localparam int AW = 16;
  localparam int EW = 8;
  localparam int CW = 16;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } req_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] baseAddr = '0;
  logic [CW-1:0] count = '0;
  logic          reqValid = 1'b0;
  logic          reqReady;
  logic [6:0]    reqOpcode = '0;
  logic [4:0]    reqRd = '0;
  logic [4:0]    reqRs1 = '0;
  logic [4:0]    reqRs2 = '0;
  logic [2:0]    reqFunct3 = '0;
  logic [6:0]    reqFunct7 = '0;
  logic [31:0]   reqConstant = '0;
  logic          imemWE;
  logic          imemReady = 1'b1;
  logic [AW-1:0] imemAddr;
  logic [31:0]   imemData;
  logic          busy;
  logic          done;
  logic [EW-1:0] errCount;
  logic [1:0]    dbg_state;

  insn_encoder_writer #(.ADDR_WIDTH(AW), .ERR_CNT_WIDTH(EW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .baseAddr(baseAddr), .count(count),
    .reqValid(reqValid), .reqReady(reqReady), .reqOpcode(reqOpcode), .reqRd(reqRd),
    .reqRs1(reqRs1), .reqRs2(reqRs2), .reqFunct3(reqFunct3), .reqFunct7(reqFunct7),
    .reqConstant(reqConstant), .imemWE(imemWE), .imemReady(imemReady),
    .imemAddr(imemAddr), .imemData(imemData), .busy(busy), .done(done),
    .errCount(errCount), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW+31:0] exp_q[$];
  logic [AW-1:0]  m_addr;
  int             m_err;
  int             ready_mode = 0;   // 0 always ready, 1 random, 2 never
  int             force_low = 0;
  bit             stall_after_first = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] model_encode(input req_t r);
    logic [31:0] i;
    i = r.imm;
    case (r.op)
      7'h33: return {r.f7, r.rs2, r.rs1, r.f3, r.rd, r.op};
      7'h03, 7'h0F, 7'h67, 7'h73: return {i[11:0], r.rs1, r.f3, r.rd, r.op};
      7'h13: begin
        if (r.f3 == 3'd1 || r.f3 == 3'd5) return {r.f7, i[4:0], r.rs1, r.f3, r.rd, r.op};
        return {i[11:0], r.rs1, r.f3, r.rd, r.op};
      end
      7'h23: return {i[11:5], r.rs2, r.rs1, r.f3, i[4:0], r.op};
      7'h63: return {i[12], i[10:5], r.rs2, r.rs1, r.f3, i[4:1], i[11], r.op};
      7'h37, 7'h17: return {i[31:12], r.rd, r.op};
      7'h6F: return {i[20], i[10:1], i[11], i[19:12], r.rd, r.op};
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit model_legal(input req_t r);
    bit known;
    known = (r.op inside {7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37,
                          7'h63, 7'h67, 7'h6F, 7'h73});
    if (!known) return 0;
    if (r.op == 7'h63 && (r.f3 == 3'd2 || r.f3 == 3'd3)) return 0;
    if ((r.op == 7'h63 || r.op == 7'h6F) && r.imm[0]) return 0;
    return 1;
  endfunction

  function automatic req_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm);
    req_t r;
    r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.f3 = f3; r.f7 = f7; r.imm = imm;
    return r;
  endfunction

  function automatic req_t rand_req();
    logic [6:0] ops [11];
    req_t r;
    ops = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
    r.op  = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 10)];
    r.rd  = 5'($urandom); r.rs1 = 5'($urandom); r.rs2 = 5'($urandom);
    r.f3  = 3'($urandom); r.f7  = 7'($urandom); r.imm = $urandom;
    if ((r.op == 7'h63 || r.op == 7'h6F) && $urandom_range(0, 3) != 0) r.imm[0] = 1'b0;
    return r;
  endfunction

  // ---------------- driver tasks (caller sits just after a rising edge) ----------------
  task automatic pulse_start(input logic [AW-1:0] base, input logic [CW-1:0] n, input bit modeled);
    start = 1'b1; baseAddr = base; count = n;
    @(posedge clk); #1;
    start = 1'b0;
    if (modeled) m_addr = base;
  endtask

  task automatic send(input req_t r);
    bit rdy;
    bit got;
    got = 0;
    reqOpcode = r.op; reqRd = r.rd; reqRs1 = r.rs1; reqRs2 = r.rs2;
    reqFunct3 = r.f3; reqFunct7 = r.f7; reqConstant = r.imm; reqValid = 1'b1;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk); rdy = reqReady;
      @(posedge clk);
      if (rdy) got = 1;
    end
    #1 reqValid = 1'b0;
    if (!got) begin
      check("req_accept_timeout", 32'd0, 32'd1);
    end else if (model_legal(r)) begin
      exp_q.push_back({m_addr, model_encode(r)});
      m_addr = m_addr + AW'(4);
    end else if (m_err < (1 << EW) - 1) begin
      m_err++;
    end
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 0;
    for (int k = 0; k < 4000 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err"}, 32'(errCount), 32'(m_err));
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  // ---------------- imemReady driver ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      if (force_low > 0) begin
        imemReady = 1'b0;
        force_low--;
      end else begin
        case (ready_mode)
          1:       imemReady = ($urandom_range(0, 3) != 0);
          2:       imemReady = 1'b0;
          default: imemReady = 1'b1;
        endcase
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  logic           prev_we = 1'b0;
  logic           prev_rdy = 1'b0;
  logic [AW-1:0]  prev_addr = '0;
  logic [31:0]    prev_data = '0;

  initial begin
    logic [AW+31:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_we = 1'b0;
      end else begin
        if (prev_we && !prev_rdy) begin
          check("stall_we_held", 32'(imemWE), 32'd1);
          check("stall_addr_stable", 32'(imemAddr), 32'(prev_addr));
          check("stall_data_stable", imemData, prev_data);
        end
        if (imemWE && !imemReady)
          check("stall_reqready_low", 32'(reqReady), 32'd0);
        if (imemWE && imemReady) begin
          if (exp_q.size() == 0) begin
            check("unexpected_write", 32'(imemAddr), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("write_addr", 32'(imemAddr), 32'(e[AW+31:32]));
            check("write_data", imemData, e[31:0]);
          end
          if (stall_after_first) begin
            force_low = 3;
            stall_after_first = 0;
          end
        end
        prev_we = imemWE; prev_rdy = imemReady; prev_addr = imemAddr; prev_data = imemData;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    m_addr = '0;
    m_err  = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_we", 32'(imemWE), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(errCount), 32'd0);
    check("rst_addr", 32'(imemAddr), 32'd0);
    check("rst_data", imemData, 32'd0);
    check("rst_reqready", 32'(reqReady), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // model pins against hand-encoded words
    check("pin_add",  model_encode(mk(7'h33, 3, 1, 2, 0, 0, 0)), 32'h002081B3);
    check("pin_addi", model_encode(mk(7'h13, 5, 0, 0, 0, 0, 32'hFFFFFFFF)), 32'hFFF00293);
    check("pin_sw",   model_encode(mk(7'h23, 0, 1, 2, 3'b010, 0, 8)), 32'h0020A423);
    check("pin_beq",  model_encode(mk(7'h63, 0, 1, 2, 0, 0, 32'hFFFFFFFC)), 32'hFE208EE3);
    check("pin_jal",  model_encode(mk(7'h6F, 1, 0, 0, 0, 0, 8)), 32'h008000EF);

    pulse_start(16'h0100, 1, 1);
    send(mk(7'h33, 3, 1, 2, 0, 0, 0));
    wait_done("add");

    pulse_start(16'h0040, 2, 1);
    send(mk(7'h13, 5, 0, 0, 0, 0, 32'hFFFFFFFF));
    send(mk(7'h23, 0, 1, 2, 3'b010, 0, 8));
    wait_done("addi_sw");

    pulse_start(16'h0180, 2, 1);
    send(mk(7'h63, 0, 1, 2, 0, 0, 32'hFFFFFFFC));
    send(mk(7'h6F, 1, 0, 0, 0, 0, 8));
    wait_done("beq_jal");

    stall_after_first = 1;
    pulse_start(16'h0100, 3, 1);
    for (int i = 0; i < 3; i++) send(mk(7'h33, 5'(i + 4), 1, 2, 0, 0, 0));
    wait_done("stall");

    pulse_start(16'h0300, 3, 1);
    m_err = 0;
    send(mk(7'h7F, 1, 1, 1, 0, 0, 0));
    send(mk(7'h63, 0, 1, 2, 0, 0, 2));
    send(mk(7'h33, 3, 1, 2, 0, 0, 0));
    wait_done("illegal");

    pulse_start(16'h0500, 0, 1);
    wait_done("count0");

    // address wrap, with a start in RUN that must be ignored
    pulse_start(16'hFFFC, 3, 1);
    m_err = 0;
    send(mk(7'h37, 7, 0, 0, 0, 0, 32'h12345000));
    pulse_start(16'h1234, 9, 0);
    send(mk(7'h17, 8, 0, 0, 0, 0, 32'hABCDE000));
    send(mk(7'h67, 1, 2, 0, 0, 0, 32'h00000FF0));
    wait_done("wrap");

    pulse_start(16'h0000, 260, 1);
    m_err = 0;
    for (int i = 0; i < 260; i++) send(mk(7'h00, 0, 0, 0, 0, 0, 0));
    wait_done("saturate");

    ready_mode = 1;
    for (int run = 0; run < 10; run++) begin
      int n;
      n = $urandom_range(1, 24);
      pulse_start(AW'($urandom) & ~AW'(3), CW'(n), 1);
      m_err = 0;
      for (int i = 0; i < n; i++) send(rand_req());
      wait_done("random");
    end

    // asynchronous reset with a word pending
    ready_mode = 2;
    pulse_start(16'h0200, 3, 1);
    m_err = 0;
    send(mk(7'h7F, 0, 0, 0, 0, 0, 0));
    send(mk(7'h33, 3, 1, 2, 0, 0, 0));
    @(negedge clk);
    check("pre_rst_we", 32'(imemWE), 32'd1);
    check("pre_rst_err", 32'(errCount), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_we", 32'(imemWE), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_err", 32'(errCount), 32'd0);
    exp_q.delete();
    m_err = 0;
    @(negedge clk); #2 rst = 1'b1;
    ready_mode = 0;
    @(posedge clk); #1;
    pulse_start(16'h0800, 2, 1);
    send(mk(7'h03, 4, 2, 0, 3'b010, 0, 32'h00000010));
    send(mk(7'h73, 0, 0, 0, 0, 0, 32'h00000001));
    wait_done("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
